smps_power_sequencer: RTL and testbench
=======================================

Name: smps_power_sequencer

Overview:
Top-level power-stage sequencer for the SMPS controller. Owns the duty-select setpoint driven into the PWM generator. Sequences soft-start ramp-up, steady-state run, soft-stop ramp-down, fault shutdown with timed auto-retry, and latched lockout after repeated faults. Sits between the system enable/fault logic and the PWM/duty datapath.

Parameters:
DUTY_LIM, 184, final duty-select code reached at end of ramp-up (8-bit, 1..255)
TS_DIV, 1000, i_clk cycles per timebase tick (>=2)
STEP_TICKS, 15, timebase ticks per one-LSB duty step during ramps (>=1)
RETRY_TICKS, 5000, timebase ticks spent in FAULT_WAIT before retry decision (>=1)
MAX_RETRIES, 3, consecutive faults allowed before LOCKOUT (1..7)

Ports:
i_clk  input  1  system clock
reset  input  1  asynchronous, active-low reset (asserted at 0)
i_enable  input  1  level request to run the converter (synchronous to i_clk)
i_fault  input  1  overcurrent/overvoltage flag, synchronous, level-sensitive
i_clear  input  1  single-cycle pulse; exits LOCKOUT
o_duty_sel  output  8  duty setpoint to PWM datapath
o_pwm_enable  output  1  gate-drive enable
o_power_good  output  1  high only in RUN
o_fault  output  1  high in FAULT_WAIT and LOCKOUT
o_state  output  3  current state encoding (debug/status)

Behaviour:
- All outputs registered. Reset (reset=0, async): state=OFF, duty=0, all flags 0, retry count 0, prescaler/step counters 0.
- Timebase: prescaler counts 0..TS_DIV-1 while state not OFF/LOCKOUT; tick=1 for one cycle at TS_DIV-1. Step counter counts ticks 0..STEP_TICKS-1; step=1 on tick at STEP_TICKS-1. Both counters clear on every state transition.
- States (enc): OFF=0, RAMP_UP=1, RUN=2, RAMP_DOWN=3, FAULT_WAIT=4, LOCKOUT=5.
- OFF: duty=0. i_enable=1 -> RAMP_UP next cycle.
- RAMP_UP: on step, duty+=1. When duty reaches DUTY_LIM (same edge as the increment) -> RUN. i_enable=0 -> RAMP_DOWN, duty held.
- RUN: duty held at DUTY_LIM; o_power_good=1. i_enable=0 -> RAMP_DOWN.
- RAMP_DOWN: on step, duty-=1; reaching 0 -> OFF and retry count cleared. i_enable=1 -> RAMP_UP from current duty (no restart from 0).
- Duty never wraps: saturates at 0 and DUTY_LIM.
- Fault: i_fault=1 in RAMP_UP/RUN/RAMP_DOWN -> next edge duty=0, o_pwm_enable=0, state=FAULT_WAIT, retry count+=1. Fault has priority over any simultaneous enable change or step.
- FAULT_WAIT: o_fault=1. Ignores i_fault. After RETRY_TICKS ticks: retry count==MAX_RETRIES -> LOCKOUT; else i_enable=1 -> RAMP_UP from duty 0; else OFF (retry count kept).
- LOCKOUT: o_fault=1, duty=0, timebase stopped. i_clear=1 -> OFF, retry count=0. i_clear ignored in all other states.
- o_pwm_enable = 1 iff state in {RAMP_UP, RUN, RAMP_DOWN} and duty>0 (registered alongside duty; first RAMP_UP step asserts it).
- Reset mid-operation: immediate return to reset values; no ramp-down.

Decomposition:
- smps_pkg: state enum/encoding, default constants (DUTY_LIM, TS_DIV, STEP_TICKS, RETRY_TICKS, MAX_RETRIES).
- One sub-module: smps_timebase (prescaler + step counter + retry-wait tick counter, with clear and run inputs, tick/step/wait_done outputs). FSM, duty register and retry counter stay in top.

Test Plan (TS_DIV=4, STEP_TICKS=2, DUTY_LIM=8, RETRY_TICKS=3, MAX_RETRIES=2):
- Reset release, i_enable=1 -> duty steps 0->8 once per 8 cycles; o_pwm_enable rises with duty=1; RUN and o_power_good=1 on the step to 8 (~64 cycles).
- In RUN drop i_enable -> duty 8->0 at 8-cycle steps; OFF at 0; o_power_good falls the cycle after i_enable drop.
- During RAMP_DOWN at duty=5 raise i_enable -> RAMP_UP continues 5->6 with no reset to 0.
- i_fault pulse at duty=4 with simultaneous i_enable=0 -> next edge duty=0, o_pwm_enable=0, state=4; after 12 cycles re-ramps from 0 (i_enable high) or goes OFF (low).
- Two faults without intervening clean OFF -> LOCKOUT (state=5, o_fault=1); i_enable held high has no effect; i_clear pulse -> OFF, then normal ramp.
- Assert reset low at duty=6 in RUN-bound ramp -> all outputs 0 asynchronously; retry count 0 verified by needing two new faults for lockout.

Source files
------------

// File: rtl/smps_pkg.sv
// Shared state encoding and default timing constants for the SMPS power sequencer.
package smps_pkg;

  typedef enum logic [2:0] {
    ST_OFF        = 3'd0,
    ST_RAMP_UP    = 3'd1,
    ST_RUN        = 3'd2,
    ST_RAMP_DOWN  = 3'd3,
    ST_FAULT_WAIT = 3'd4,
    ST_LOCKOUT    = 3'd5
  } stateT;

  localparam int DUTY_LIM_DEF    = 184;
  localparam int TS_DIV_DEF      = 1000;
  localparam int STEP_TICKS_DEF  = 15;
  localparam int RETRY_TICKS_DEF = 5000;
  localparam int MAX_RETRIES_DEF = 3;

  // States in which the power stage may be switching.
  function automatic logic isActive(input stateT s);
    return (s == ST_RAMP_UP) || (s == ST_RUN) || (s == ST_RAMP_DOWN);
  endfunction

endpackage

// File: rtl/smps_timebase.sv
// Prescaled tick, ramp step and retry-wait timing for the power sequencer.
module smps_timebase
  import smps_pkg::*;
#(
  parameter int TS_DIV      = TS_DIV_DEF,
  parameter int STEP_TICKS  = STEP_TICKS_DEF,
  parameter int RETRY_TICKS = RETRY_TICKS_DEF
) (
  input  logic i_clk,
  input  logic reset,
  input  logic i_run,
  input  logic i_clear,
  output logic o_step,
  output logic o_waitDone
);

  localparam int PW = $clog2(TS_DIV);
  localparam int SW = $clog2(STEP_TICKS + 1);
  localparam int WW = $clog2(RETRY_TICKS + 1);

  logic [PW-1:0] r_presc;
  logic [SW-1:0] r_stepCnt;
  logic [WW-1:0] r_waitCnt;
  logic          w_tick;
  logic          w_stepWrap;
  logic          w_waitWrap;

  assign w_tick     = i_run && (r_presc == PW'(TS_DIV - 1));
  assign w_stepWrap = (r_stepCnt == SW'(STEP_TICKS - 1));
  assign w_waitWrap = (r_waitCnt == WW'(RETRY_TICKS - 1));
  assign o_step     = w_tick && w_stepWrap;
  assign o_waitDone = w_tick && w_waitWrap;

  // Counters restart from zero on every state change so each state sees full periods.
  always_ff @(posedge i_clk or negedge reset) begin
    if (!reset) begin
      r_presc   <= '0;
      r_stepCnt <= '0;
      r_waitCnt <= '0;
    end else if (i_clear || !i_run) begin
      r_presc   <= '0;
      r_stepCnt <= '0;
      r_waitCnt <= '0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + PW'(1);
      if (w_tick) begin
        r_stepCnt <= w_stepWrap ? '0 : r_stepCnt + SW'(1);
        r_waitCnt <= w_waitWrap ? '0 : r_waitCnt + WW'(1);
      end
    end
  end

endmodule

// File: rtl/smps_power_sequencer.sv
// Power-stage sequencer: soft-start/stop duty ramps, fault retry and lockout.
module smps_power_sequencer
  import smps_pkg::*;
#(
  parameter int DUTY_LIM    = DUTY_LIM_DEF,
  parameter int TS_DIV      = TS_DIV_DEF,
  parameter int STEP_TICKS  = STEP_TICKS_DEF,
  parameter int RETRY_TICKS = RETRY_TICKS_DEF,
  parameter int MAX_RETRIES = MAX_RETRIES_DEF
) (
  input  logic       i_clk,
  input  logic       reset,
  input  logic       i_enable,
  input  logic       i_fault,
  input  logic       i_clear,
  output logic [7:0] o_duty_sel,
  output logic       o_pwm_enable,
  output logic       o_power_good,
  output logic       o_fault,
  output logic [2:0] o_state
);

  localparam logic [7:0] LIM       = 8'(DUTY_LIM);
  localparam logic [2:0] RETRY_MAX = 3'(MAX_RETRIES);

  stateT       r_state;
  stateT       w_nextState;
  logic [7:0]  r_duty;
  logic [7:0]  w_nextDuty;
  logic [2:0]  r_retryCnt;
  logic [2:0]  w_nextRetry;
  logic        r_pwmEn;
  logic        r_powerGood;
  logic        r_fault;
  logic        w_run;
  logic        w_clear;
  logic        w_step;
  logic        w_waitDone;
  logic        w_faultHit;

  assign w_run      = (r_state != ST_OFF) && (r_state != ST_LOCKOUT);
  assign w_clear    = (w_nextState != r_state);
  assign w_faultHit = i_fault && isActive(r_state);

  smps_timebase #(
    .TS_DIV      (TS_DIV),
    .STEP_TICKS  (STEP_TICKS),
    .RETRY_TICKS (RETRY_TICKS)
  ) u_timebase (
    .i_clk      (i_clk),
    .reset      (reset),
    .i_run      (w_run),
    .i_clear    (w_clear),
    .o_step     (w_step),
    .o_waitDone (w_waitDone)
  );

  // Fault preempts every enable change or ramp step in the active states.
  always_comb begin
    w_nextState = r_state;
    w_nextDuty  = r_duty;
    w_nextRetry = r_retryCnt;
    if (w_faultHit) begin
      w_nextState = ST_FAULT_WAIT;
      w_nextDuty  = 8'd0;
      w_nextRetry = (r_retryCnt == 3'd7) ? r_retryCnt : r_retryCnt + 3'd1;
    end else begin
      case (r_state)
        ST_OFF: begin
          w_nextDuty = 8'd0;
          if (i_enable) w_nextState = ST_RAMP_UP;
        end
        ST_RAMP_UP: begin
          if (!i_enable) begin
            w_nextState = ST_RAMP_DOWN;
          end else if (w_step) begin
            if (r_duty >= LIM - 8'd1) begin
              w_nextDuty  = LIM;
              w_nextState = ST_RUN;
            end else begin
              w_nextDuty = r_duty + 8'd1;
            end
          end
        end
        ST_RUN: begin
          w_nextDuty = LIM;
          if (!i_enable) w_nextState = ST_RAMP_DOWN;
        end
        ST_RAMP_DOWN: begin
          if (i_enable) begin
            w_nextState = ST_RAMP_UP;
          end else if (w_step) begin
            if (r_duty <= 8'd1) begin
              w_nextDuty  = 8'd0;
              w_nextState = ST_OFF;
              w_nextRetry = 3'd0;
            end else begin
              w_nextDuty = r_duty - 8'd1;
            end
          end
        end
        ST_FAULT_WAIT: begin
          w_nextDuty = 8'd0;
          if (w_waitDone) begin
            if (r_retryCnt >= RETRY_MAX) w_nextState = ST_LOCKOUT;
            else if (i_enable)           w_nextState = ST_RAMP_UP;
            else                         w_nextState = ST_OFF;
          end
        end
        ST_LOCKOUT: begin
          w_nextDuty = 8'd0;
          if (i_clear) begin
            w_nextState = ST_OFF;
            w_nextRetry = 3'd0;
          end
        end
        default: begin
          w_nextState = ST_OFF;
          w_nextDuty  = 8'd0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_OFF;
      r_duty      <= 8'd0;
      r_retryCnt  <= 3'd0;
      r_pwmEn     <= 1'b0;
      r_powerGood <= 1'b0;
      r_fault     <= 1'b0;
    end else begin
      r_state     <= w_nextState;
      r_duty      <= w_nextDuty;
      r_retryCnt  <= w_nextRetry;
      r_pwmEn     <= isActive(w_nextState) && (w_nextDuty != 8'd0);
      r_powerGood <= (w_nextState == ST_RUN);
      r_fault     <= (w_nextState == ST_FAULT_WAIT) || (w_nextState == ST_LOCKOUT);
    end
  end

  assign o_duty_sel   = r_duty;
  assign o_pwm_enable = r_pwmEn;
  assign o_power_good = r_powerGood;
  assign o_fault      = r_fault;
  assign o_state      = r_state;

endmodule

// File: tb/tb_smps_power_sequencer.sv
// Directed scoreboard bench for smps_power_sequencer using small timing parameters.
module tb_smps_power_sequencer;

  localparam logic [2:0] S_OFF = 3'd0;
  localparam logic [2:0] S_RU  = 3'd1;
  localparam logic [2:0] S_RUN = 3'd2;
  localparam logic [2:0] S_RD  = 3'd3;
  localparam logic [2:0] S_FW  = 3'd4;
  localparam logic [2:0] S_LO  = 3'd5;

  typedef struct {
    string       tag;
    logic [13:0] val;
  } expT;

  logic       clock;
  logic       reset;
  logic       enable;
  logic       fault;
  logic       clear;
  logic [7:0] dutySel;
  logic       pwmEnable;
  logic       powerGood;
  logic       faultOut;
  logic [2:0] state;

  expT expQ[$];
  int  checks = 0;
  int  errors = 0;

  smps_power_sequencer #(
    .DUTY_LIM    (8),
    .TS_DIV      (4),
    .STEP_TICKS  (2),
    .RETRY_TICKS (3),
    .MAX_RETRIES (2)
  ) dut (
    .i_clk        (clock),
    .reset        (reset),
    .i_enable     (enable),
    .i_fault      (fault),
    .i_clear      (clear),
    .o_duty_sel   (dutySel),
    .o_pwm_enable (pwmEnable),
    .o_power_good (powerGood),
    .o_fault      (faultOut),
    .o_state      (state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic applyStimulus(input logic en, input logic flt, input logic clr);
    enable = en;
    fault  = flt;
    clear  = clr;
  endtask

  task automatic checkOutput();
    expT         e;
    logic [13:0] obs;
    checks++;
    if (expQ.size() == 0) begin
      errors++;
      $display("[TB] FAIL scoreboard empty at time %0t", $time);
    end else begin
      e   = expQ.pop_front();
      obs = {state, dutySel, pwmEnable, powerGood, faultOut};
      assert (obs === e.val) else begin
        errors++;
        $error("[TB] FAIL %s observed state=%0d duty=%0d pwm=%b pg=%b flt=%b expected state=%0d duty=%0d pwm=%b pg=%b flt=%b",
               e.tag, obs[13:11], obs[10:3], obs[2], obs[1], obs[0],
               e.val[13:11], e.val[10:3], e.val[2], e.val[1], e.val[0]);
      end
    end
  endtask

  task automatic expectAfter(input int n, input string tag, input logic [2:0] st,
                             input logic [7:0] du, input logic pw, input logic pg,
                             input logic fl);
    expT e;
    e.tag = tag;
    e.val = {st, du, pw, pg, fl};
    expQ.push_back(e);
    repeat (n) @(negedge clock);
    checkOutput();
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    #3 reset = 1'b0;
    #1 expectAfter(0, "resetState", S_OFF, 8'd0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    expectAfter(1, "idleOff", S_OFF, 8'd0, 1'b0, 1'b0, 1'b0);

    applyStimulus(1'b1, 1'b0, 1'b0);
    expectAfter(1, "rampStart", S_RU, 8'd0, 1'b0, 1'b0, 1'b0);
    expectAfter(7, "preFirstStep", S_RU, 8'd0, 1'b0, 1'b0, 1'b0);
    expectAfter(1, "firstStep", S_RU, 8'd1, 1'b1, 1'b0, 1'b0);
    for (int n = 2; n <= 8; n++)
      expectAfter(8, "rampUp", (n == 8) ? S_RUN : S_RU, 8'(n), 1'b1, (n == 8), 1'b0);

    applyStimulus(1'b0, 1'b0, 1'b0);
    expectAfter(1, "pgDrop", S_RD, 8'd8, 1'b1, 1'b0, 1'b0);
    for (int n = 7; n >= 0; n--)
      expectAfter(8, "rampDown", (n == 0) ? S_OFF : S_RD, 8'(n), (n != 0), 1'b0, 1'b0);

    applyStimulus(1'b1, 1'b0, 1'b0);
    expectAfter(1, "restart", S_RU, 8'd0, 1'b0, 1'b0, 1'b0);
    for (int n = 1; n <= 7; n++)
      expectAfter(8, "rampUp2", S_RU, 8'(n), 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    expectAfter(1, "dropAt7", S_RD, 8'd7, 1'b1, 1'b0, 1'b0);
    expectAfter(8, "down6", S_RD, 8'd6, 1'b1, 1'b0, 1'b0);
    expectAfter(8, "down5", S_RD, 8'd5, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    expectAfter(1, "resumeAt5", S_RU, 8'd5, 1'b1, 1'b0, 1'b0);
    expectAfter(7, "holdAt5", S_RU, 8'd5, 1'b1, 1'b0, 1'b0);
    expectAfter(1, "resumeStep", S_RU, 8'd6, 1'b1, 1'b0, 1'b0);

    applyStimulus(1'b0, 1'b0, 1'b0);
    expectAfter(1, "drop2", S_RD, 8'd6, 1'b1, 1'b0, 1'b0);
    expectAfter(8, "down5b", S_RD, 8'd5, 1'b1, 1'b0, 1'b0);
    expectAfter(8, "down4", S_RD, 8'd4, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    expectAfter(1, "fault1", S_FW, 8'd0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    expectAfter(11, "waitHold", S_FW, 8'd0, 1'b0, 1'b0, 1'b1);
    expectAfter(1, "retryRamp", S_RU, 8'd0, 1'b0, 1'b0, 1'b0);
    expectAfter(8, "reRamp1", S_RU, 8'd1, 1'b1, 1'b0, 1'b0);
    expectAfter(24, "reRamp4", S_RU, 8'd4, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    expectAfter(1, "fault2", S_FW, 8'd0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    expectAfter(12, "lockout", S_LO, 8'd0, 1'b0, 1'b0, 1'b1);
    expectAfter(20, "lockHold", S_LO, 8'd0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0);
    expectAfter(1, "lockFault", S_LO, 8'd0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    expectAfter(1, "cleared", S_OFF, 8'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    expectAfter(1, "postClear", S_RU, 8'd0, 1'b0, 1'b0, 1'b0);
    expectAfter(8, "postClearStep", S_RU, 8'd1, 1'b1, 1'b0, 1'b0);

    applyStimulus(1'b1, 1'b1, 1'b0);
    expectAfter(1, "fault5", S_FW, 8'd0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    expectAfter(12, "retry5", S_RU, 8'd0, 1'b0, 1'b0, 1'b0);
    expectAfter(48, "duty6", S_RU, 8'd6, 1'b1, 1'b0, 1'b0);
    #2 reset = 1'b0;
    #1 expectAfter(0, "asyncReset", S_OFF, 8'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    expectAfter(1, "afterReset", S_RU, 8'd0, 1'b0, 1'b0, 1'b0);
    expectAfter(8, "afterResetStep", S_RU, 8'd1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    expectAfter(1, "fault3", S_FW, 8'd0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    expectAfter(12, "waitToOff", S_OFF, 8'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    expectAfter(1, "ramp3", S_RU, 8'd0, 1'b0, 1'b0, 1'b0);
    expectAfter(8, "ramp3Step", S_RU, 8'd1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    expectAfter(1, "fault4", S_FW, 8'd0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    expectAfter(12, "lockout2", S_LO, 8'd0, 1'b0, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
